// File: rtl/note_track.sv
// Scrolling 4-lane note chart: pulls rows from the RNG each step, scores key presses on row 0.
// Outputs are registered; rnd_en is a decode of the step FSM gated by enable.
module note_track #(
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 12500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [3:0]           rnd,
  output logic                 rnd_en,
  input  logic [3:0]           keys,
  output logic [4*DEPTH-1:0]   track,
  output logic                 hit,
  output logic                 wrong,
  output logic                 miss,
  output logic [15:0]          score,
  output logic [7:0]           streak
);

  localparam int CW = $clog2(STEP_CYCLES);

  typedef enum logic [1:0] {S_WAIT, S_REQ, S_LOAD, S_SHIFT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    prev;
  logic [3:0]    rnd_q;

  logic [3:0]    rise, hits, wrongs, row0_c, newrow;
  logic [2:0]    pop;
  logic [16:0]   score_sum;
  logic [8:0]    streak_sum;
  logic [15:0]   score_nxt;
  logic [7:0]    streak_nxt;

  always_comb begin
    rise       = keys & ~prev;
    hits       = enable ? (rise & track[3:0])  : 4'h0;
    wrongs     = enable ? (rise & ~track[3:0]) : 4'h0;
    row0_c     = track[3:0] & ~hits;
    newrow     = (rnd_q == 4'hF) ? 4'h6 : rnd_q;
    pop        = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
    score_sum  = 17'(score) + 17'(pop);
    streak_sum = 9'(streak) + 9'(pop);
    score_nxt  = score_sum[16]  ? 16'hFFFF : score_sum[15:0];
    streak_nxt = streak_sum[8]  ? 8'hFF    : streak_sum[7:0];
  end

  assign rnd_en = enable && (state == S_REQ || state == S_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_WAIT;
      cnt    <= '0;
      prev   <= 4'h0;
      rnd_q  <= 4'h0;
      track  <= '0;
      hit    <= 1'b0;
      wrong  <= 1'b0;
      miss   <= 1'b0;
      score  <= 16'h0;
      streak <= 8'h0;
    end else begin
      prev  <= keys;
      hit   <= 1'b0;
      wrong <= 1'b0;
      miss  <= 1'b0;
      if (enable) begin
        score       <= score_nxt;
        hit         <= |hits;
        wrong       <= |wrongs;
        track[3:0]  <= row0_c;
        // A wrong press or an unplayed note leaving row 0 both break the streak.
        if (|wrongs || (state == S_SHIFT && |row0_c))
          streak <= 8'h0;
        else if (|hits)
          streak <= streak_nxt;
        case (state)
          S_WAIT: begin
            if (cnt == CW'(STEP_CYCLES - 1)) begin
              cnt   <= '0;
              state <= S_REQ;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_REQ:  state <= S_LOAD;
          S_LOAD: begin
            rnd_q <= rnd;
            state <= S_SHIFT;
          end
          S_SHIFT: begin
            track <= {newrow, track[4*DEPTH-1:4]};
            miss  <= |row0_c;
            state <= S_WAIT;
          end
          default: state <= S_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_track.sv
// Randomized bench for note_track against a step-phase reference model of the note chart.
module tb_note_track;

  localparam int DEPTH = 4;
  localparam int STEP  = 4;

  logic               clk = 1'b0;
  logic               rst, enable, rnd_en, hit, wrong, miss;
  logic [3:0]         rnd, keys;
  logic [4*DEPTH-1:0] track;
  logic [15:0]        score;
  logic [7:0]         streak;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [3:0] m_row [DEPTH];
  logic [3:0] m_prev, m_rnd;
  int         m_phase;
  int         m_score, m_streak;
  logic       m_hit, m_wrong, m_miss;
  int         rnd_en_cnt, miss_cnt;

  note_track #(.DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rnd(rnd), .rnd_en(rnd_en),
    .keys(keys), .track(track), .hit(hit), .wrong(wrong), .miss(miss),
    .score(score), .streak(streak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) m_row[r] = 4'h0;
    m_prev = 0; m_rnd = 0; m_phase = 0; m_score = 0; m_streak = 0;
    m_hit = 0; m_wrong = 0; m_miss = 0;
  endtask

  // Phases 0..STEP-1 wait, then request, load, shift.
  task automatic model_step();
    logic [3:0] rise, h, w, outgoing;
    int nh;
    rise   = keys & ~m_prev;
    m_prev = keys;
    m_hit = 0; m_wrong = 0; m_miss = 0;
    if (enable) begin
      h  = rise & m_row[0];
      w  = rise & ~m_row[0];
      nh = $countones(h);
      m_row[0] = m_row[0] & ~h;
      m_score  = (m_score + nh > 65535) ? 65535 : m_score + nh;
      if (h != 0) begin
        m_hit    = 1;
        m_streak = (m_streak + nh > 255) ? 255 : m_streak + nh;
      end
      if (w != 0) begin
        m_wrong  = 1;
        m_streak = 0;
      end
      if (m_phase == STEP + 1) m_rnd = rnd;
      if (m_phase == STEP + 2) begin
        outgoing = m_row[0];
        for (int r = 0; r < DEPTH - 1; r++) m_row[r] = m_row[r+1];
        m_row[DEPTH-1] = (m_rnd == 4'hF) ? 4'h6 : m_rnd;
        if (outgoing != 0) begin
          m_miss   = 1;
          m_streak = 0;
        end
      end
      m_phase = (m_phase == STEP + 2) ? 0 : m_phase + 1;
    end
  endtask

  task automatic check_all();
    logic [4*DEPTH-1:0] pk;
    logic exp_en;
    for (int r = 0; r < DEPTH; r++) pk[4*r +: 4] = m_row[r];
    exp_en = enable && (m_phase == STEP || m_phase == STEP + 1);
    chk("track",  64'(track),  64'(pk));
    chk("score",  64'(score),  64'(m_score));
    chk("streak", 64'(streak), 64'(m_streak));
    chk("hit",    64'(hit),    64'(m_hit));
    chk("wrong",  64'(wrong),  64'(m_wrong));
    chk("miss",   64'(miss),   64'(m_miss));
    chk("rnd_en", 64'(rnd_en), 64'(exp_en));
    if (rnd_en) rnd_en_cnt++;
    if (miss)   miss_cnt++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_track"},  64'(track),  64'h0);
    chk({tag, "_score"},  64'(score),  64'h0);
    chk({tag, "_streak"}, 64'(streak), 64'h0);
    chk({tag, "_pulses"}, 64'({rnd_en, hit, wrong, miss}), 64'h0);
  endtask

  // mode 0: held rnd=A, no keys; 1: random mix; 2: tap on row-0 notes
  task automatic drive(input int mode);
    int sel;
    case (mode)
      0: begin enable = 1; keys = 0; rnd = 4'hA; end
      1: begin
        rnd    = 4'($urandom);
        enable = ($urandom_range(0, 9) != 0);
        sel    = $urandom_range(0, 3);
        if (sel == 0)      keys = 4'h0;
        else if (sel == 1) keys = m_row[0];
        else if (sel == 2) keys = 4'($urandom);
      end
      default: begin
        enable = 1;
        rnd    = 4'($urandom);
        keys   = (keys == 0) ? m_row[0] : 4'h0;
      end
    endcase
  endtask

  task automatic cycle(input int mode);
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all();
    drive(mode);
  endtask

  initial begin
    int budget;
    rst = 1; enable = 0; keys = 0; rnd = 0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 0; enable = 1; rnd = 4'hA;

    // held rnd: 2 rnd_en cycles per 7, A reaches row 0 and misses out
    rnd_en_cnt = 0; miss_cnt = 0;
    for (int i = 0; i < 70; i++) cycle(0);
    chk("rnd_en_duty", 64'(rnd_en_cnt), 64'd20);
    chk("miss_count",  64'(miss_cnt),   64'd6);

    for (int i = 0; i < 2000; i++) cycle(1);

    // frozen while disabled
    enable = 1; keys = 0;
    for (int i = 0; i < 2; i++) cycle(0);
    enable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); model_step();
      @(negedge clk); check_all();
    end
    enable = 1;
    for (int i = 0; i < 20; i++) cycle(0);

    // asynchronous reset during the load cycle
    budget = 20;
    while (!(m_phase == STEP + 1) && budget > 0) begin
      cycle(0);
      budget--;
    end
    chk("load_reached", 64'(budget > 0), 64'd1);
    #2 rst = 1;
    model_reset();
    #1 check_zero("rst_load");
    @(negedge clk);
    rst = 0;

    // score saturation from a preloaded near-full value
    for (int i = 0; i < 60; i++) cycle(2);
    enable = 0; keys = 0;
    @(negedge clk);
    force dut.score = 16'hFFFE;
    #1 release dut.score;
    m_score = 16'hFFFE;
    for (int i = 0; i < 200; i++) cycle(2);
    chk("score_sat", 64'(score), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
